// File: rtl/serial_arith_pkg.sv
// ============================================================================
// serial_arith_pkg : shared types and constants for the bit-serial add/sub
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/full_add_sub_cell.sv
// ============================================================================
// full_add_sub_cell : single-bit full adder; subtraction is obtained by the
// caller inverting y and seeding cin with 1.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module full_add_sub_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// serial_add_sub : LSB-first bit-serial adder/subtractor, one bit per clock.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             w_sum;
  logic             w_carry;

  full_add_sub_cell u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (w_sum),
    .cout (w_carry)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with mode.
          a_sh_d  = a;
          b_sh_d  = (mode == MODE_SUB) ? ~b : b;
          carry_d = mode;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = {w_sum, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = w_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // carry_q here is the carry into the MSB; borrow is the inverted carry.
          cout_d  = (mode_q == MODE_SUB) ? ~w_carry : w_carry;
          ovf_d   = carry_q ^ w_carry;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != SHIFT);
    busy_d  = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// tb_serial_add_sub : directed and exhaustive checks of serial_add_sub
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] res8;

  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, done4, cout4, ovf4;
  logic [3:0] res4;

  int tests = 0;
  int fails = 0;
  int done8_seen = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
  );

  always @(negedge clk) if (done8) done8_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input bit w4, input logic m, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] r, output logic co, output logic ov, output int lat);
    if (w4) begin start4 = 1'b1; mode4 = m; a4 = av[3:0]; b4 = bv[3:0]; end
    else    begin start8 = 1'b1; mode8 = m; a8 = av;      b8 = bv;      end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    lat = 1;
    while (!(w4 ? done4 : done8) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r  = w4 ? {4'h0, res4} : res8;
    co = w4 ? cout4 : cout8;
    ov = w4 ? ovf4 : ovf8;
    @(negedge clk);
    check("done_one_cycle", w4 ? done4 : done8, 1'b0);
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] r;
    logic co, ov;
    int lat;
    int waited;

    vecs[0] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h0A, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", ready8, 1'b1);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_result", res8, 8'h00);
    check("rst_cout_ovf", {cout8, ovf8}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort mid-operation with an asynchronous reset
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; mode8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_busy", {busy8, ready8}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {ready8, busy8, done8, cout8, ovf8, res8}, {5'b10000, 8'h00});
    done8_seen = 0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done8_seen, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single operations
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].mode, vecs[i].a, vecs[i].b, r, co, ov, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_cout", i), co, vecs[i].co);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
      check($sformatf("vec%0d_latency", i), lat, 9);
    end

    // start held high through SHIFT with changing operands
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    waited = 1;
    while (!done8 && waited < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
      @(negedge clk);
      waited++;
    end
    start8 = 1'b0;
    check("held_start_result", res8, 8'h33);
    check("held_start_latency", waited, 9);
    @(negedge clk);
    check("held_start_idle", {ready8, busy8, done8}, 3'b100);

    // Back-to-back: restart in the DONE cycle
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
    @(negedge clk);
    start8 = 1'b0;
    waited = 1;
    while (!done8 && waited < 40) begin @(negedge clk); waited++; end
    check("b2b_first_result", res8, 8'h30);
    check("b2b_first_ready", ready8, 1'b1);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'h03; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_reloaded", {busy8, done8}, 2'b10);
    waited = 1;
    while (!done8 && waited < 40) begin @(negedge clk); waited++; end
    check("b2b_second_gap", waited, 9);
    check("b2b_second_result", res8, 8'h02);
    check("b2b_second_flags", {cout8, ovf8}, 2'b00);
    @(negedge clk);

    // Exhaustive WIDTH=4 sweep
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          logic [4:0] full;
          logic [3:0] er;
          logic ec, eo;
          if (m == 0) begin
            full = 5'(x) + 5'(y);
            er = full[3:0];
            ec = full[4];
            eo = (x[3] == y[3]) && (er[3] != x[3]);
          end else begin
            full = 5'(x) - 5'(y);
            er = full[3:0];
            ec = (x < y);
            eo = (x[3] != y[3]) && (er[3] != x[3]);
          end
          run_op(1'b1, 1'(m), 8'(x), 8'(y), r, co, ov, lat);
          check($sformatf("w4 m%0d %0h,%0h result", m, x, y), r, {4'h0, er});
          check($sformatf("w4 m%0d %0h,%0h cout", m, x, y), co, ec);
          check($sformatf("w4 m%0d %0h,%0h ovf", m, x, y), ov, eo);
          check($sformatf("w4 m%0d %0h,%0h latency", m, x, y), lat, 5);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
